// File: rtl/gamepad_scanner.sv
// gamepad_scanner: frame-synchronous reader for N_PADS Mega-Drive 3-button pads.
// Optional autorepeat on Pressed when GAMEPAD_AUTOREPEAT_EN is defined.
// Ports: Clock50/Reset (async, active-high); v_sync (async, active low) starts a scan;
//  Pinos[6p+:6] = P1,P2,P3,P4,P6,P9 of pad p (active low); Select per pad;
//  Botoes/Pressed[8p+:8] = Start,C,B,A,Right,Left,Down,Up; Presente per pad; Valid pulse.
module gamepad_scanner #(
    parameter int N_PADS          = 2,
    parameter int SETTLE_CYCLES   = 250,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_FRAMES   = 8
) (
    input  logic                  Clock50,
    input  logic                  Reset,
    input  logic                  v_sync,
    input  logic [6*N_PADS-1:0]   Pinos,
    output logic [N_PADS-1:0]     Select,
    output logic [8*N_PADS-1:0]   Botoes,
    output logic [8*N_PADS-1:0]   Pressed,
    output logic [N_PADS-1:0]     Presente,
    output logic                  Valid
);

    localparam int NB = 8 * N_PADS;
    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEL_H  = 2'd1;
    localparam logic [1:0] SEL_L  = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    if (N_PADS < 1 || SETTLE_CYCLES < 2 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("gamepad_scanner: parameter out of range");
    end

    logic [1:0]           state;
    logic [CW-1:0]        settle_cnt;
    logic                 vs_s1, vs_s2, vs_prev;
    logic [6*N_PADS-1:0]  pin_s1, pin_s2;
    logic [6*N_PADS-1:0]  samp_h;
    // Only P3,P4,P6,P9 carry information while Select is low
    logic [4*N_PADS-1:0]  samp_l;
    logic                 fall;
    logic                 settle_done;

    logic [N_PADS-1:0]    pres;
    logic [NB-1:0]        raw;
    logic [NB-1:0]        stable_nxt;
    logic [NB-1:0]        pulse;
    logic [DW-1:0]        dcnt     [NB];
    logic [DW-1:0]        dcnt_nxt [NB];

    assign fall        = vs_prev & ~vs_s2;
    assign settle_done = (settle_cnt == CW'(SETTLE_CYCLES - 1));
    assign Select      = {N_PADS{state != SEL_L}};

    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_prev <= 1'b1;
            pin_s1  <= '1;
            pin_s2  <= '1;
        end else begin
            vs_s1   <= v_sync;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
            pin_s1  <= Pinos;
            pin_s2  <= pin_s1;
        end
    end

    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            samp_h     <= '1;
            samp_l     <= '1;
        end else begin
            unique case (state)
                IDLE: begin
                    settle_cnt <= '0;
                    if (fall) state <= SEL_H;
                end
                SEL_H: begin
                    if (settle_done) begin
                        samp_h     <= pin_s2;
                        settle_cnt <= '0;
                        state      <= SEL_L;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                SEL_L: begin
                    if (settle_done) begin
                        for (int p = 0; p < N_PADS; p++)
                            samp_l[4*p +: 4] <= pin_s2[6*p+2 +: 4];
                        settle_cnt <= '0;
                        state      <= UPDATE;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pres = '0;
        raw  = '0;
        for (int p = 0; p < N_PADS; p++) begin
            // A connected pad grounds P3/P4 while Select is low
            pres[p] = ~samp_l[4*p+0] & ~samp_l[4*p+1];
            if (pres[p])
                raw[8*p +: 8] = ~{samp_l[4*p+3], samp_h[6*p+5], samp_h[6*p+4],
                                  samp_l[4*p+2], samp_h[6*p+3], samp_h[6*p+2],
                                  samp_h[6*p+1], samp_h[6*p+0]};
        end
    end

    always_comb begin
        stable_nxt = Botoes;
        for (int i = 0; i < NB; i++) begin
            dcnt_nxt[i] = '0;
            if (raw[i] != Botoes[i]) begin
                if (dcnt[i] == DW'(DEBOUNCE_FRAMES - 1))
                    stable_nxt[i] = raw[i];
                else
                    dcnt_nxt[i] = dcnt[i] + DW'(1);
            end
        end
    end

`ifdef GAMEPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(2 * REPEAT_FRAMES + 1);

    logic [RW-1:0] rcnt     [NB];
    logic [RW-1:0] rcnt_nxt [NB];
    logic [NB-1:0] rep_hit;

    // Counter advances only on scans where the bit was already held
    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < NB; i++) begin
            rcnt_nxt[i] = '0;
            if (stable_nxt[i] & Botoes[i]) begin
                if (rcnt[i] + RW'(1) == RW'(2 * REPEAT_FRAMES)) begin
                    rep_hit[i]  = 1'b1;
                    rcnt_nxt[i] = RW'(REPEAT_FRAMES);
                end else begin
                    rcnt_nxt[i] = rcnt[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NB; i++) rcnt[i] <= '0;
        end else if (state == UPDATE) begin
            for (int i = 0; i < NB; i++) rcnt[i] <= rcnt_nxt[i];
        end
    end

    assign pulse = (stable_nxt & ~Botoes) | rep_hit;
`else
    assign pulse = stable_nxt & ~Botoes;
`endif

    always_ff @(posedge Clock50 or posedge Reset) begin
        if (Reset) begin
            Botoes   <= '0;
            Pressed  <= '0;
            Presente <= '0;
            Valid    <= 1'b0;
            for (int i = 0; i < NB; i++) dcnt[i] <= '0;
        end else begin
            Valid   <= 1'b0;
            Pressed <= '0;
            if (state == UPDATE) begin
                Botoes   <= stable_nxt;
                Pressed  <= pulse;
                Presente <= pres;
                Valid    <= 1'b1;
                for (int i = 0; i < NB; i++) dcnt[i] <= dcnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_gamepad_scanner.sv
// tb_gamepad_scanner: random pad stimulus against a per-scan reference model.
// Pad pins are produced by a behavioural Mega-Drive pad driven from Select.
module tb_gamepad_scanner;

    localparam int S   = 250;
    localparam int DF  = 2;
    localparam int LAT = 2 * S + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v_sync = 1'b1;
    logic [11:0] pinos;
    logic [1:0]  select;
    logic [15:0] botoes, pressed;
    logic [1:0]  presente;
    logic        valid;

    int total = 0;
    int bad   = 0;

    logic [7:0]  btn [2];
    logic [1:0]  here;

    logic [15:0] st;
    logic [15:0] exp_p;
    int          dc [16];

    gamepad_scanner #(
        .N_PADS(2), .SETTLE_CYCLES(S), .DEBOUNCE_FRAMES(DF), .REPEAT_FRAMES(8)
    ) dut (
        .Clock50(clk), .Reset(rst), .v_sync(v_sync), .Pinos(pinos),
        .Select(select), .Botoes(botoes), .Pressed(pressed),
        .Presente(presente), .Valid(valid)
    );

    always #10 clk = ~clk;

    // Pad: bits 7..0 = Start,C,B,A,Right,Left,Down,Up; pins P9,P6,P4,P3,P2,P1
    always_comb begin
        pinos = '1;
        for (int p = 0; p < 2; p++) begin
            if (here[p]) begin
                if (select[p])
                    pinos[6*p +: 6] = ~{btn[p][6], btn[p][5], btn[p][3],
                                        btn[p][2], btn[p][1], btn[p][0]};
                else
                    pinos[6*p +: 6] = {~btn[p][7], ~btn[p][4], 2'b00,
                                       ~btn[p][1], ~btn[p][0]};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        st = '0;
        exp_p = '0;
        for (int i = 0; i < 16; i++) dc[i] = 0;
    endtask

    // One scan: a bit flips after DF consecutive scans that disagree with it
    task automatic model_scan();
        logic r, old;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 8; b++) begin
                r   = here[p] ? btn[p][b] : 1'b0;
                old = st[8*p+b];
                if (r != old) begin
                    dc[8*p+b]++;
                    if (dc[8*p+b] == DF) begin
                        st[8*p+b] = r;
                        dc[8*p+b] = 0;
                    end
                end else begin
                    dc[8*p+b] = 0;
                end
                exp_p[8*p+b] = st[8*p+b] & ~old;
            end
        end
    endtask

    task automatic run_scan(input string tag);
        int n;
        bit got;
        n = 0;
        got = 0;
        model_scan();
        @(negedge clk) v_sync = 1'b0;
        while (n < LAT + 20 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid) got = 1;
        end
        check({tag, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_lat"}, 32'(n), 32'(LAT));
            check({tag, "_botoes"}, 32'(botoes), 32'(st));
            check({tag, "_pressed"}, 32'(pressed), 32'(exp_p));
            check({tag, "_presente"}, 32'(presente), 32'(here));
            @(negedge clk);
            check({tag, "_valid_drop"}, 32'(valid), 32'd0);
            check({tag, "_pressed_drop"}, 32'(pressed), 32'd0);
        end
        v_sync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int vcnt, first_n;
        logic [15:0] cap_b, cap_p;

        btn[0] = '0;
        btn[1] = '0;
        here   = 2'b11;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_select", 32'(select), 32'h3);
        check("rst_botoes", 32'(botoes), 32'h0);
        check("rst_pressed", 32'(pressed), 32'h0);
        check("rst_presente", 32'(presente), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // A + Right held on pad0
        btn[0] = 8'h18;
        run_scan("dec1");
        check("dec1_notyet", 32'(botoes[7:0]), 32'h00);
        run_scan("dec2");
        check("dec2_botoes", 32'(botoes[7:0]), 32'h18);

        // Start bouncing every scan never settles
        for (int k = 0; k < 4; k++) begin
            btn[0] = (k % 2 == 0) ? 8'h98 : 8'h18;
            run_scan("bounce");
            check("bounce_start", 32'(botoes[7]), 32'd0);
        end

        // Absent pad1 with everything held
        btn[1] = 8'hFF;
        here   = 2'b01;
        run_scan("abs1");
        run_scan("abs2");
        check("abs_bot1", 32'(botoes[15:8]), 32'h00);
        check("abs_pres", 32'(presente), 32'h1);
        here = 2'b11;

        for (int k = 0; k < 30; k++) begin
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 2) == 0) btn[p] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) here = 2'($urandom);
            else if ($urandom_range(0, 3) == 0) here = 2'b11;
            run_scan("rnd");
        end

        // Second edge during a scan is ignored
        here = 2'b11;
        btn[0] = 8'h21;
        model_scan();
        vcnt = 0;
        first_n = 0;
        cap_b = '0;
        cap_p = '0;
        @(negedge clk) v_sync = 1'b0;
        for (int n = 1; n <= 2 * LAT + 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 5) v_sync = 1'b1;
            if (n == 100) v_sync = 1'b0;
            if (valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    first_n = n;
                    cap_b = botoes;
                    cap_p = pressed;
                end
            end
        end
        check("ovr_count", 32'(vcnt), 32'd1);
        check("ovr_lat", 32'(first_n), 32'(LAT));
        check("ovr_botoes", 32'(cap_b), 32'(st));
        check("ovr_pressed", 32'(cap_p), 32'(exp_p));
        v_sync = 1'b1;
        repeat (4) @(negedge clk);

        // Make sure something is latched, then reset mid SEL_L
        btn[0] = 8'h81;
        run_scan("pre1");
        run_scan("pre2");
        check("pre_botoes", 32'(botoes[0]), 32'd1);
        @(negedge clk) v_sync = 1'b0;
        repeat (S + 50) @(negedge clk);
        check("midscan_select", 32'(select), 32'h0);
        rst = 1'b1;
        #1;
        check("mrst_select", 32'(select), 32'h3);
        check("mrst_botoes", 32'(botoes), 32'h0);
        check("mrst_presente", 32'(presente), 32'h0);
        check("mrst_valid", 32'(valid), 32'h0);
        model_reset();
        @(negedge clk) v_sync = 1'b1;
        @(negedge clk) rst = 1'b0;
        vcnt = 0;
        repeat (LAT + 20) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        check("mrst_no_valid", 32'(vcnt), 32'd0);
        run_scan("post1");
        run_scan("post2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
